// File: rtl/riscv_core_issue_scoreboard_pkg.sv
// Shared types and constants for the decode-stage issue scoreboard.
// Holds the bypass-select codes, the stage indices and the per-stage in-flight record.
package riscv_core_pkg;

    localparam int NSTAGE = 5;
    localparam int AW     = 5;
    localparam int SW     = 4;

    localparam logic [2:0] BYP_RF = 3'd0;
    localparam logic [2:0] BYP_X0 = 3'd1;
    localparam logic [2:0] BYP_X1 = 3'd2;
    localparam logic [2:0] BYP_X2 = 3'd3;
    localparam logic [2:0] BYP_X3 = 3'd4;
    localparam logic [2:0] BYP_W  = 3'd5;

    localparam int ST_X0 = 0;
    localparam int ST_X1 = 1;
    localparam int ST_X2 = 2;
    localparam int ST_X3 = 3;
    localparam int ST_W  = 4;

    // is_long marks a muldiv producer whose result only exists in W
    typedef struct packed {
        logic          val;
        logic          wen;
        logic [AW-1:0] rd;
        logic          is_long;
        logic [SW-1:0] slot;
    } stage_rec_t;

    function automatic logic [2:0] byp_of_stage(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/riscv_core_issue_scoreboard_if.sv
// Decode / ROB-side signal bundle of the issue scoreboard.
// master = decode/ROB environment, slave = scoreboard.
interface riscv_core_issue_scoreboard_if;
    import riscv_core_pkg::*;

    logic          dec_val;
    logic          dec_rs1_ren;
    logic [AW-1:0] dec_rs1;
    logic          dec_rs2_ren;
    logic [AW-1:0] dec_rs2;
    logic          dec_wen;
    logic [AW-1:0] dec_rd;
    logic          dec_long;
    logic          rob_alloc_req_rdy;
    logic [SW-1:0] rob_alloc_resp_slot;

    logic          rob_alloc_req_val;
    logic          issue_fire;
    logic          dec_stall;
    logic [2:0]    op1_byp_sel;
    logic [2:0]    op2_byp_sel;
    logic          rob_fill_val;
    logic [SW-1:0] rob_fill_slot;
    logic          wb_wen;
    logic [AW-1:0] wb_waddr;

    modport master (
        output dec_val, dec_rs1_ren, dec_rs1, dec_rs2_ren, dec_rs2,
               dec_wen, dec_rd, dec_long, rob_alloc_req_rdy, rob_alloc_resp_slot,
        input  rob_alloc_req_val, issue_fire, dec_stall, op1_byp_sel, op2_byp_sel,
               rob_fill_val, rob_fill_slot, wb_wen, wb_waddr
    );

    modport slave (
        input  dec_val, dec_rs1_ren, dec_rs1, dec_rs2_ren, dec_rs2,
               dec_wen, dec_rd, dec_long, rob_alloc_req_rdy, rob_alloc_resp_slot,
        output rob_alloc_req_val, issue_fire, dec_stall, op1_byp_sel, op2_byp_sel,
               rob_fill_val, rob_fill_slot, wb_wen, wb_waddr
    );

endinterface

// File: rtl/riscv_core_issue_scoreboard_match.sv
// Youngest-producer priority encoder for one source operand.
// X0 is the youngest stage, so the lowest matching index wins.
module riscv_core_sb_match
    import riscv_core_pkg::*;
(
    input  stage_rec_t [NSTAGE-1:0] stg,
    input  logic                    ren,
    input  logic [AW-1:0]           rs,
    output logic                    hit,
    output logic [2:0]              stage_idx,
    output logic                    is_long
);

    always_comb begin
        hit       = 1'b0;
        stage_idx = 3'd0;
        is_long   = 1'b0;
        if (ren && (rs != '0)) begin
            // Walk oldest to youngest so a younger match overrides an older one.
            for (int i = NSTAGE - 1; i >= 0; i--) begin
                if (stg[i].val && stg[i].wen && (stg[i].rd == rs)) begin
                    hit       = 1'b1;
                    stage_idx = 3'(i);
                    is_long   = stg[i].is_long;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_core_issue_scoreboard.sv
// In-order issue scoreboard: tracks writes through X0..X3/W, picks stall vs bypass, drives ROB fill.
// Optional stall counters are compiled in with RISCV_SB_STATS_EN.
module riscv_core_issue_scoreboard
    import riscv_core_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    riscv_core_issue_scoreboard_if.slave  sb
`ifdef RISCV_SB_STATS_EN
    ,
    output logic [31:0]                   stat_raw_stalls,
    output logic [31:0]                   stat_rob_stalls
`endif
);

    stage_rec_t [NSTAGE-1:0] stg_q;
    stage_rec_t [NSTAGE-1:0] stg_d;

    logic       hit1, hit2;
    logic [2:0] idx1, idx2;
    logic       long1, long2;
    logic       raw_stall1, raw_stall2;
    logic       raw_stall, rob_stall;
    logic       stall, fire;
    logic [2:0] sel1, sel2;
    stage_rec_t w_rec;

    riscv_core_sb_match u_match_rs1 (
        .stg       (stg_q),
        .ren       (sb.dec_rs1_ren),
        .rs        (sb.dec_rs1),
        .hit       (hit1),
        .stage_idx (idx1),
        .is_long   (long1)
    );

    riscv_core_sb_match u_match_rs2 (
        .stg       (stg_q),
        .ren       (sb.dec_rs2_ren),
        .rs        (sb.dec_rs2),
        .hit       (hit2),
        .stage_idx (idx2),
        .is_long   (long2)
    );

    // A muldiv result can only be forwarded once it reaches W.
    assign raw_stall1 = hit1 && long1 && (idx1 != 3'(ST_W));
    assign raw_stall2 = hit2 && long2 && (idx2 != 3'(ST_W));
    assign raw_stall  = raw_stall1 || raw_stall2;
    assign rob_stall  = !sb.rob_alloc_req_rdy;
    assign stall      = sb.dec_val && (raw_stall || rob_stall);
    assign fire       = sb.dec_val && !stall;

    always_comb begin
        sel1 = BYP_RF;
        sel2 = BYP_RF;
        if (hit1 && !raw_stall1) sel1 = byp_of_stage(idx1);
        if (hit2 && !raw_stall2) sel2 = byp_of_stage(idx2);
    end

    always_comb begin
        stg_d = '0;
        if (fire) begin
            stg_d[ST_X0].val     = 1'b1;
            stg_d[ST_X0].wen     = sb.dec_wen;
            stg_d[ST_X0].rd      = sb.dec_rd;
            stg_d[ST_X0].is_long = sb.dec_long;
            stg_d[ST_X0].slot    = sb.rob_alloc_resp_slot;
        end
        for (int i = 1; i < NSTAGE; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stg_q <= '0;
        else       stg_q <= stg_d;
    end

    assign w_rec = stg_q[ST_W];

    assign sb.dec_stall         = stall;
    assign sb.issue_fire        = fire;
    assign sb.rob_alloc_req_val = fire;
    assign sb.op1_byp_sel       = sel1;
    assign sb.op2_byp_sel       = sel2;
    assign sb.rob_fill_val      = w_rec.val;
    assign sb.rob_fill_slot     = w_rec.slot;
    assign sb.wb_wen            = w_rec.val && w_rec.wen;
    assign sb.wb_waddr          = w_rec.rd;

`ifdef RISCV_SB_STATS_EN
    logic [31:0] raw_cnt_q, raw_cnt_d;
    logic [31:0] rob_cnt_q, rob_cnt_d;

    // Both causes are counted independently when they coincide.
    always_comb begin
        raw_cnt_d = raw_cnt_q;
        rob_cnt_d = rob_cnt_q;
        if (sb.dec_val && raw_stall) raw_cnt_d = raw_cnt_q + 32'd1;
        if (sb.dec_val && rob_stall) rob_cnt_d = rob_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_cnt_q <= '0;
            rob_cnt_q <= '0;
        end else begin
            raw_cnt_q <= raw_cnt_d;
            rob_cnt_q <= rob_cnt_d;
        end
    end

    assign stat_raw_stalls = raw_cnt_q;
    assign stat_rob_stalls = rob_cnt_q;
`endif

endmodule
